// File: rtl/alu_exec_stage.sv
// Execute stage of a 5-stage pipeline. It forwards the operands, runs the ALU and resolves
// branch/jump redirects combinationally, then feeds the EX/MEM register.
module alu_exec_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_e,
    input  logic              stall_e,
    input  logic              flush_e,
    input  logic [2:0]        alu_control_e,
    input  logic [DATA_W-1:0] rd1_e,
    input  logic [DATA_W-1:0] rd2_e,
    input  logic [DATA_W-1:0] imm_ext_e,
    input  logic [DATA_W-1:0] pc_e,
    input  logic              alu_src_e,
    input  logic [1:0]        forward_a_e,
    input  logic [1:0]        forward_b_e,
    input  logic [DATA_W-1:0] result_w,
    input  logic [4:0]        rd_e,
    input  logic              reg_write_e,
    input  logic              branch_e,
    input  logic              jump_e,
    output logic              valid_m,
    output logic              reg_write_m,
    output logic              illegal_m,
    output logic [DATA_W-1:0] alu_result_m,
    output logic [DATA_W-1:0] write_data_m,
    output logic [4:0]        rd_m,
    output logic              pc_src_e,
    output logic [DATA_W-1:0] pc_target_e
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;

    function automatic logic signed [DATA_W-1:0] fwd_sel(
        input logic [1:0]        sel,
        input logic [DATA_W-1:0] reg_val,
        input logic [DATA_W-1:0] wb_val,
        input logic [DATA_W-1:0] mem_val
    );
        case (sel)
            2'b01:   return wb_val;
            2'b10:   return mem_val;
            default: return reg_val;
        endcase
    endfunction

    function automatic logic op_illegal(input logic [2:0] op);
        return (op > OP_SLT);
    endfunction

    // Two's-complement wrap falls out of the fixed-width add/sub; SLT uses a signed compare,
    // so it stays correct even where a - b would overflow.
    function automatic logic signed [DATA_W-1:0] alu_compute(
        input logic [2:0]               op,
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLT:  return (a < b) ? DATA_W'(1) : '0;
            default: return '0;
        endcase
    endfunction

    logic signed [DATA_W-1:0] src_a;
    logic signed [DATA_W-1:0] fwd_b;
    logic signed [DATA_W-1:0] src_b;
    logic signed [DATA_W-1:0] alu_result;
    logic                     illegal;
    logic                     zero;

    always_comb begin
        src_a      = fwd_sel(forward_a_e, rd1_e, result_w, alu_result_m);
        fwd_b      = fwd_sel(forward_b_e, rd2_e, result_w, alu_result_m);
        src_b      = alu_src_e ? imm_ext_e : fwd_b;
        alu_result = alu_compute(alu_control_e, src_a, src_b);
        illegal    = valid_e & op_illegal(alu_control_e);
        zero       = (alu_result == '0);
    end

    assign pc_src_e    = valid_e & ~flush_e & ((branch_e & zero) | jump_e);
    assign pc_target_e = pc_e + imm_ext_e;

    // EX/MEM boundary: reset > flush > stall > load
    always_ff @(posedge clk) begin
        if (reset || flush_e) begin
            valid_m      <= 1'b0;
            reg_write_m  <= 1'b0;
            illegal_m    <= 1'b0;
            alu_result_m <= '0;
            write_data_m <= '0;
            rd_m         <= '0;
        end else if (!stall_e) begin
            valid_m      <= valid_e;
            reg_write_m  <= reg_write_e & valid_e & ~illegal;
            illegal_m    <= illegal;
            alu_result_m <= alu_result;
            write_data_m <= fwd_b;
            rd_m         <= rd_e;
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed cases plus randomized traffic checked
// against a behavioural model of the EX stage and its EX/MEM register.
module tb_alu_exec_stage;

    logic        clk = 1'b0;
    logic        reset, valid_e, stall_e, flush_e;
    logic [2:0]  alu_control_e;
    logic [31:0] rd1_e, rd2_e, imm_ext_e, pc_e, result_w;
    logic        alu_src_e;
    logic [1:0]  forward_a_e, forward_b_e;
    logic [4:0]  rd_e;
    logic        reg_write_e, branch_e, jump_e;
    logic        valid_m, reg_write_m, illegal_m;
    logic [31:0] alu_result_m, write_data_m;
    logic [4:0]  rd_m;
    logic        pc_src_e;
    logic [31:0] pc_target_e;

    int n_cmp = 0;
    int n_bad = 0;

    // model of the registered outputs
    logic        e_valid, e_rw, e_ill;
    logic [31:0] e_alu, e_wd;
    logic [4:0]  e_rd;

    always #5 clk = ~clk;

    alu_exec_stage dut (
        .clk(clk), .reset(reset), .valid_e(valid_e), .stall_e(stall_e), .flush_e(flush_e),
        .alu_control_e(alu_control_e), .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_ext_e(imm_ext_e),
        .pc_e(pc_e), .alu_src_e(alu_src_e), .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .result_w(result_w), .rd_e(rd_e), .reg_write_e(reg_write_e), .branch_e(branch_e),
        .jump_e(jump_e), .valid_m(valid_m), .reg_write_m(reg_write_m), .illegal_m(illegal_m),
        .alu_result_m(alu_result_m), .write_data_m(write_data_m), .rd_m(rd_m),
        .pc_src_e(pc_src_e), .pc_target_e(pc_target_e)
    );

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return (sa < sb) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] regv);
        if (sel == 2'd1) return result_w;
        if (sel == 2'd2) return e_alu;
        return regv;
    endfunction

    function automatic logic [31:0] ref_result();
        logic [31:0] b;
        b = alu_src_e ? imm_ext_e : ref_fwd(forward_b_e, rd2_e);
        return ref_alu(alu_control_e, ref_fwd(forward_a_e, rd1_e), b);
    endfunction

    function automatic logic ref_pc_src();
        return valid_e & ~flush_e & ((branch_e & (ref_result() == 32'd0)) | jump_e);
    endfunction

    // Advance the model by one edge from the current inputs, then let the DUT take the same edge.
    task automatic tick();
        logic        ill;
        logic [31:0] nalu, nwd;
        ill  = valid_e && (alu_control_e > 3'd5);
        nalu = ref_result();
        nwd  = ref_fwd(forward_b_e, rd2_e);
        if (reset || flush_e) begin
            e_valid = 0; e_rw = 0; e_ill = 0; e_alu = 0; e_wd = 0; e_rd = 0;
        end else if (!stall_e) begin
            e_valid = valid_e; e_rw = reg_write_e & valid_e & ~ill; e_ill = ill;
            e_alu = nalu; e_wd = nwd; e_rd = rd_e;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        reset = 0; valid_e = 0; stall_e = 0; flush_e = 0; alu_control_e = 0;
        rd1_e = 0; rd2_e = 0; imm_ext_e = 0; pc_e = 0; result_w = 0; alu_src_e = 0;
        forward_a_e = 0; forward_b_e = 0; rd_e = 0; reg_write_e = 0; branch_e = 0; jump_e = 0;
    endtask

    task automatic load_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        set_idle();
        valid_e = 1; reg_write_e = 1; rd_e = 5'd7; alu_control_e = op; rd1_e = a; rd2_e = b;
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1; valid_e = 1; reg_write_e = 1; rd1_e = 32'h55; rd2_e = 32'h66; rd_e = 5'd9;
        pc_e = 32'h10; imm_ext_e = 32'h20; flush_e = 0; stall_e = 1;
        tick();
        tick();
        n_cmp++; if (pc_target_e !== 32'h30) begin n_bad++; $display("FAIL reset_pc_target got %h want %h", pc_target_e, 32'h30); end
        n_cmp++; if (valid_m !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", valid_m); end
        n_cmp++; if (reg_write_m !== 1'b0) begin n_bad++; $display("FAIL reset_reg_write got %b want 0", reg_write_m); end
        n_cmp++; if (illegal_m !== 1'b0) begin n_bad++; $display("FAIL reset_illegal got %b want 0", illegal_m); end
        n_cmp++; if (alu_result_m !== 32'h0) begin n_bad++; $display("FAIL reset_alu got %h want 0", alu_result_m); end
        n_cmp++; if (write_data_m !== 32'h0) begin n_bad++; $display("FAIL reset_wdata got %h want 0", write_data_m); end
        n_cmp++; if (rd_m !== 5'h0) begin n_bad++; $display("FAIL reset_rd got %h want 0", rd_m); end
    endtask

    task automatic test_add_sub_wrap();
        load_op(3'b000, 32'hFFFF_FFFF, 32'd1);
        tick();
        n_cmp++; if (alu_result_m !== 32'h0) begin n_bad++; $display("FAIL add_wrap got %h want 0", alu_result_m); end
        n_cmp++; if (valid_m !== 1'b1 || reg_write_m !== 1'b1 || rd_m !== 5'd7) begin n_bad++; $display("FAIL add_ctrl got v%b rw%b rd%0d want v1 rw1 rd7", valid_m, reg_write_m, rd_m); end
        n_cmp++; if (write_data_m !== 32'd1) begin n_bad++; $display("FAIL add_wdata got %h want 1", write_data_m); end
        load_op(3'b001, 32'd0, 32'd1);
        tick();
        n_cmp++; if (alu_result_m !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL sub_wrap got %h want ffffffff", alu_result_m); end
    endtask

    task automatic test_logic_ops();
        logic [31:0] want [3];
        want[0] = 32'h0000_0F00; want[1] = 32'hF0FF_FFF0; want[2] = 32'hF0FF_F0F0;
        for (int i = 0; i < 3; i++) begin
            load_op(3'(i + 2), 32'hF0F0_FF00, 32'h000F_0FF0);
            tick();
            n_cmp++; if (alu_result_m !== want[i]) begin n_bad++; $display("FAIL logic_op%0d got %h want %h", i + 2, alu_result_m, want[i]); end
        end
    endtask

    task automatic test_slt();
        load_op(3'b101, 32'h8000_0000, 32'h7FFF_FFFF);
        tick();
        n_cmp++; if (alu_result_m !== 32'd1) begin n_bad++; $display("FAIL slt_neg_lt_pos got %h want 1", alu_result_m); end
        load_op(3'b101, 32'h7FFF_FFFF, 32'h8000_0000);
        tick();
        n_cmp++; if (alu_result_m !== 32'd0) begin n_bad++; $display("FAIL slt_pos_lt_neg got %h want 0", alu_result_m); end
    endtask

    task automatic test_forward();
        load_op(3'b000, 32'd5, 32'd7);
        tick();
        n_cmp++; if (alu_result_m !== 32'd12) begin n_bad++; $display("FAIL fwd_first got %0d want 12", alu_result_m); end
        load_op(3'b000, 32'd100, 32'd3);
        forward_a_e = 2'b10;
        tick();
        n_cmp++; if (alu_result_m !== 32'd15) begin n_bad++; $display("FAIL fwd_own_result got %0d want 15", alu_result_m); end
        load_op(3'b000, 32'd1, 32'd2);
        forward_b_e = 2'b01; result_w = 32'hAA; alu_src_e = 1; imm_ext_e = 32'd4; forward_a_e = 2'b11;
        tick();
        n_cmp++; if (alu_result_m !== 32'd5 || write_data_m !== 32'hAA) begin n_bad++; $display("FAIL fwd_wb_imm got alu %h wd %h want alu 5 wd aa", alu_result_m, write_data_m); end
    endtask

    task automatic test_branch();
        load_op(3'b001, 32'h1234, 32'h1234);
        branch_e = 1; pc_e = 32'h100; imm_ext_e = 32'hFFFF_FFF8;
        #1;
        n_cmp++; if (pc_src_e !== 1'b1) begin n_bad++; $display("FAIL branch_taken got %b want 1", pc_src_e); end
        n_cmp++; if (pc_target_e !== 32'hF8) begin n_bad++; $display("FAIL branch_target got %h want f8", pc_target_e); end
        flush_e = 1;
        #1;
        n_cmp++; if (pc_src_e !== 1'b0) begin n_bad++; $display("FAIL branch_flushed got %b want 0", pc_src_e); end
        flush_e = 0; rd2_e = 32'h1235;
        #1;
        n_cmp++; if (pc_src_e !== 1'b0) begin n_bad++; $display("FAIL branch_not_taken got %b want 0", pc_src_e); end
        tick();
    endtask

    task automatic test_stall_flush_reset();
        load_op(3'b000, 32'd4, 32'd5);
        tick();
        n_cmp++; if (alu_result_m !== 32'd9) begin n_bad++; $display("FAIL stall_setup got %0d want 9", alu_result_m); end
        for (int i = 0; i < 3; i++) begin
            stall_e = 1; rd1_e = $urandom; rd2_e = $urandom; rd_e = 5'(i);
            tick();
            n_cmp++; if (alu_result_m !== 32'd9 || valid_m !== 1'b1 || rd_m !== 5'd7) begin n_bad++; $display("FAIL stall_hold%0d got alu %0d v %b rd %0d want 9 1 7", i, alu_result_m, valid_m, rd_m); end
        end
        stall_e = 1; flush_e = 1;
        tick();
        n_cmp++; if (valid_m !== 1'b0 || reg_write_m !== 1'b0 || alu_result_m !== 32'd0) begin n_bad++; $display("FAIL flush_over_stall got v %b rw %b alu %h want 0 0 0", valid_m, reg_write_m, alu_result_m); end
        load_op(3'b010, 32'hFF, 32'h0F);
        tick();
        stall_e = 1; reset = 1;
        tick();
        n_cmp++; if ({valid_m, reg_write_m, illegal_m} !== 3'b0 || alu_result_m !== 0 || write_data_m !== 0 || rd_m !== 0) begin n_bad++; $display("FAIL reset_mid_stall got v%b rw%b alu %h wd %h rd %0d want all 0", valid_m, reg_write_m, alu_result_m, write_data_m, rd_m); end
        load_op(3'b000, 32'd2, 32'd3);
        tick();
        n_cmp++; if (alu_result_m !== 32'd5 || valid_m !== 1'b1) begin n_bad++; $display("FAIL first_after_reset got alu %0d v %b want 5 1", alu_result_m, valid_m); end
        load_op(3'b000, 32'd8, 32'd8);
        reset = 1;
        tick();
        n_cmp++; if ({valid_m, reg_write_m, illegal_m} !== 3'b0 || alu_result_m !== 0 || write_data_m !== 0 || rd_m !== 0) begin n_bad++; $display("FAIL reset_during_load got v%b rw%b alu %h wd %h rd %0d want all 0", valid_m, reg_write_m, alu_result_m, write_data_m, rd_m); end
    endtask

    task automatic test_illegal();
        load_op(3'b110, 32'd3, 32'd4);
        tick();
        n_cmp++; if (alu_result_m !== 32'd0 || illegal_m !== 1'b1 || reg_write_m !== 1'b0) begin n_bad++; $display("FAIL illegal_op got alu %h ill %b rw %b want 0 1 0", alu_result_m, illegal_m, reg_write_m); end
        load_op(3'b111, 32'd3, 32'd4);
        valid_e = 0;
        tick();
        n_cmp++; if (illegal_m !== 1'b0 || valid_m !== 1'b0 || write_data_m !== 32'd4) begin n_bad++; $display("FAIL bubble_illegal got ill %b v %b wd %h want 0 0 4", illegal_m, valid_m, write_data_m); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 31) == 0);
            flush_e = ($urandom_range(0, 7) == 0);
            stall_e = ($urandom_range(0, 4) == 0);
            valid_e = ($urandom_range(0, 5) != 0);
            alu_control_e = 3'($urandom_range(0, 7));
            rd1_e = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            rd2_e = ($urandom_range(0, 3) == 0) ? rd1_e : $urandom;
            imm_ext_e = $urandom; pc_e = $urandom; result_w = $urandom;
            alu_src_e = 1'($urandom_range(0, 1));
            forward_a_e = 2'($urandom_range(0, 3));
            forward_b_e = 2'($urandom_range(0, 3));
            rd_e = 5'($urandom_range(0, 31));
            reg_write_e = 1'($urandom_range(0, 1));
            branch_e = 1'($urandom_range(0, 1));
            jump_e = ($urandom_range(0, 5) == 0);
            #1;
            n_cmp++; if (pc_src_e !== ref_pc_src() || pc_target_e !== pc_e + imm_ext_e) begin n_bad++; $display("FAIL rand_redirect[%0d] got src %b tgt %h want %b %h", i, pc_src_e, pc_target_e, ref_pc_src(), pc_e + imm_ext_e); end
            tick();
            n_cmp++; if ({valid_m, reg_write_m, illegal_m, rd_m} !== {e_valid, e_rw, e_ill, e_rd} || alu_result_m !== e_alu || write_data_m !== e_wd) begin
                n_bad++;
                $display("FAIL rand_regs[%0d] got v%b rw%b il%b rd%0d alu %h wd %h want v%b rw%b il%b rd%0d alu %h wd %h", i,
                         valid_m, reg_write_m, illegal_m, rd_m, alu_result_m, write_data_m, e_valid, e_rw, e_ill, e_rd, e_alu, e_wd);
            end
        end
    endtask

    initial begin
        e_valid = 0; e_rw = 0; e_ill = 0; e_alu = 0; e_wd = 0; e_rd = 0;
        set_idle();
        test_reset();
        test_add_sub_wrap();
        test_logic_ops();
        test_slt();
        test_forward();
        test_branch();
        test_stall_flush_reset();
        test_illegal();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
